// File: rtl/fetch_pkg.sv
// Shared definitions for the two-operand fetch engine: state encoding and default widths.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    CAPB = 3'd3,
    DONE = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/operand_reg.sv
// Operand storage register with load enable and asynchronous active-low clear.
module operand_reg #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/operand_fetch.sv
// Fetches operands A and B from a synchronous memory with two back-to-back reads.
module operand_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic              busy,
  output logic              done
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_addr_b;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_busy;
  logic              r_done;
  logic              w_load_a;
  logic              w_load_b;

  // Outputs are registered alongside the state, so each arm sets the values
  // for the state being entered. addrA goes straight into r_mem_addr; only
  // addrB needs a holding register until RDB.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr_b   <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RDA;
            r_addr_b   <= addrB;
            r_mem_addr <= addrA;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        RDA: begin
          r_state    <= RDB;
          r_mem_addr <= r_addr_b;
          r_mem_rd   <= 1'b1;
        end
        RDB: begin
          r_state    <= CAPB;
          r_mem_addr <= '0;
          r_mem_rd   <= 1'b0;
        end
        CAPB: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_mem_addr <= '0;
          r_mem_rd   <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Read data trails the strobe by one cycle: A arrives during RDB, B during CAPB.
  assign w_load_a = (r_state == RDB);
  assign w_load_b = (r_state == CAPB);

  operand_reg #(.W(DATA_W)) u_op_a (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_load  (w_load_a),
    .i_d     (mem_data),
    .o_q     (opA)
  );

  operand_reg #(.W(DATA_W)) u_op_b (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_load  (w_load_b),
    .i_d     (mem_data),
    .o_q     (opB)
  );

  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a synchronous one-cycle-latency memory model.
module tb_operand_fetch;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [15:0] addrA;
  logic [15:0] addrB;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem [0:255];

  operand_fetch #(.ADDR_W(16), .DATA_W(16)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .start    (start),
    .addrA    (addrA),
    .addrB    (addrB),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_rd) mem_data <= mem[mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; addrA = '0; addrB = '0;
    #1;
    n_vec++; if ({busy, done, mem_rd} !== 3'b000) begin n_err++; $display("FAIL por_ctrl got %b exp 000", {busy, done, mem_rd}); end
    n_vec++; if (mem_addr !== 16'h0) begin n_err++; $display("FAIL por_mem_addr got %h exp 0000", mem_addr); end
    n_vec++; if ({opA, opB} !== 32'h0) begin n_err++; $display("FAIL por_ops got %h exp 00000000", {opA, opB}); end
    tick(); reset = 1'b1; tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
    // Mid-fetch asynchronous reset, asserted between edges while in RDB
    addrA = 16'h0010; addrB = 16'h0020; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    n_vec++; if ({busy, done, mem_rd} !== 3'b000) begin n_err++; $display("FAIL async_ctrl got %b exp 000", {busy, done, mem_rd}); end
    n_vec++; if (mem_addr !== 16'h0) begin n_err++; $display("FAIL async_mem_addr got %h exp 0000", mem_addr); end
    #1 reset = 1'b1;
    tick(); tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic_fetch();
    addrA = 16'h0010; addrB = 16'h0020; start = 1'b1;
    tick();
    start = 1'b0; addrA = 16'h0030; addrB = 16'h0040;
    n_vec++; if ({busy, mem_rd, done} !== 3'b110) begin n_err++; $display("FAIL rda_ctrl got %b exp 110", {busy, mem_rd, done}); end
    n_vec++; if (mem_addr !== 16'h0010) begin n_err++; $display("FAIL rda_addr got %h exp 0010", mem_addr); end
    tick();
    n_vec++; if ({mem_rd, done} !== 2'b10) begin n_err++; $display("FAIL rdb_ctrl got %b exp 10", {mem_rd, done}); end
    n_vec++; if (mem_addr !== 16'h0020) begin n_err++; $display("FAIL rdb_addr got %h exp 0020", mem_addr); end
    tick();
    n_vec++; if ({busy, mem_rd, done} !== 3'b100) begin n_err++; $display("FAIL capb_ctrl got %b exp 100", {busy, mem_rd, done}); end
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL capb_addr got %h exp 0000", mem_addr); end
    n_vec++; if (opA !== 16'h1234) begin n_err++; $display("FAIL capb_opA got %h exp 1234", opA); end
    tick();
    n_vec++; if ({busy, done} !== 2'b11) begin n_err++; $display("FAIL done_pulse got %b exp 11", {busy, done}); end
    n_vec++; if ({opA, opB} !== 32'h1234_ABCD) begin n_err++; $display("FAIL basic_ops got %h exp 1234abcd", {opA, opB}); end
    tick();
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL back_idle got %b exp 00", {busy, done}); end
  endtask

  task automatic test_same_addr();
    int rd_cycles = 0;
    int done_cnt = 0;
    addrA = 16'h0010; addrB = 16'h0010; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_rd) begin
        rd_cycles++;
        n_vec++; if (mem_addr !== 16'h0010) begin n_err++; $display("FAIL same_rd_addr got %h exp 0010", mem_addr); end
      end
      if (done) done_cnt++;
      tick();
    end
    n_vec++; if (rd_cycles !== 2) begin n_err++; $display("FAIL same_rd_cycles got %0d exp 2", rd_cycles); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL same_done_cnt got %0d exp 1", done_cnt); end
    n_vec++; if ({opA, opB} !== 32'h1234_1234) begin n_err++; $display("FAIL same_ops got %h exp 12341234", {opA, opB}); end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    addrA = 16'h0010; addrB = 16'h0020; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    addrA = 16'h0030; addrB = 16'h0040; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_cnt++;
      tick();
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy got %b exp 0", busy); end
    n_vec++; if ({opA, opB} !== 32'h1234_ABCD) begin n_err++; $display("FAIL ign_ops got %h exp 1234abcd", {opA, opB}); end
  endtask

  task automatic test_reset_capb();
    int done_cnt = 0;
    addrA = 16'h0020; addrB = 16'h0010; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    n_vec++; if (opA !== 16'hABCD) begin n_err++; $display("FAIL rc_opA_pre got %h exp abcd", opA); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if ({opA, opB} !== 32'h0) begin n_err++; $display("FAIL rc_ops_clr got %h exp 00000000", {opA, opB}); end
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL rc_no_done got %0d exp 0", done_cnt); end
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick();
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL rc_refetch_done got %0d exp 1", done_cnt); end
    n_vec++; if ({opA, opB} !== 32'hABCD_1234) begin n_err++; $display("FAIL rc_refetch_ops got %h exp abcd1234", {opA, opB}); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    addrA = 16'h0010; addrB = 16'h0020; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_done = ((k % 5) == 4);
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL b2b_done k=%0d got %b exp %b", k, done, exp_done); end
      if (k >= 4) begin
        n_vec++; if ({opA, opB} !== 32'h1234_ABCD) begin n_err++; $display("FAIL b2b_ops k=%0d got %h exp 1234abcd", k, {opA, opB}); end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain_busy got %b exp 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 + 16'(i);
    mem[8'h10] = 16'h1234;
    mem[8'h20] = 16'hABCD;
    mem[8'h30] = 16'hDEAD;
    mem[8'h40] = 16'hBEEF;
    mem_data = '0;
    test_reset();
    test_basic_fetch();
    test_same_addr();
    test_start_ignored();
    test_reset_capb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, giving the memory address width.
REQ-002 The module SHALL have parameter DATA_W, default 16, giving the memory word and operand width.
REQ-003 Port CLK, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset; reset=0 SHALL force reset state immediately.
REQ-005 Port start, input, 1 bit: request to fetch two operands.
REQ-006 Port addrA, input, ADDR_W bits: address of operand A, sampled with start.
REQ-007 Port addrB, input, ADDR_W bits: address of operand B, sampled with start.
REQ-008 Port mem_addr, output, ADDR_W bits: read address to synchronous memory.
REQ-009 Port mem_rd, output, 1 bit: memory read strobe.
REQ-010 Port mem_data, input, DATA_W bits: memory read data, valid one cycle after mem_rd.
REQ-011 Port opA, output, DATA_W bits: fetched operand A.
REQ-012 Port opB, output, DATA_W bits: fetched operand B.
REQ-013 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse when opA and opB are both valid.

Function
REQ-015 The FSM SHALL have states IDLE, RDA, RDB, CAPB, DONE.
REQ-016 In IDLE, start=1 at an edge SHALL latch addrA/addrB and move to RDA; start=0 SHALL stay in IDLE.
REQ-017 In RDA, the outputs SHALL be mem_rd=1 and mem_addr=latched addrA, and the next state SHALL be RDB unconditionally.
REQ-018 In RDB, the outputs SHALL be mem_rd=1 and mem_addr=latched addrB; the exit edge SHALL load opA from mem_data and move to CAPB.
REQ-019 In CAPB, the outputs SHALL be mem_rd=0 and mem_addr=0; the exit edge SHALL load opB from mem_data and move to DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-021 Latency: done SHALL go high in the third cycle after the edge that samples start, which is four edges from start to return to IDLE.
REQ-022 Outside RDA/RDB, mem_rd SHALL be 0 and mem_addr SHALL be 0.
REQ-023 start SHALL be ignored in every state except IDLE; no queuing SHALL occur.
REQ-024 If start is held high, a new fetch SHALL begin on the edge after DONE→IDLE, giving one IDLE cycle between fetches.
REQ-025 opA/opB SHALL hold their values until overwritten by the next fetch; opA updates before opB.
REQ-026 addrA==addrB SHALL still issue two reads, with opA==opB.
REQ-027 Address changes on addrA/addrB after the start edge SHALL NOT affect the fetch in progress.

Reset
REQ-028 Reset SHALL set the state to IDLE and opA, opB, mem_addr, the latched addresses, mem_rd, busy and done to 0.
REQ-029 Reset mid-operation SHALL abort the fetch, with no done pulse; after reset deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-030 The state encoding and default widths SHALL live in a shared package, fetch_pkg.
REQ-031 opA/opB storage SHALL use one sub-module, operand_reg: DATA_W register with load enable and async active-low reset, instantiated twice.

Verification
REQ-032 reset=0 mid-cycle -> all outputs are 0 immediately; busy=0 after release.
REQ-033 Memory model mem[0x0010]=0x1234, mem[0x0020]=0xABCD; start with addrA=0x0010, addrB=0x0020 -> mem_addr 0x0010 then 0x0020; done pulse in cycle 3; opA=0x1234, opB=0xABCD.
REQ-034 addrA=addrB=0x0010 -> opA=opB=0x1234, with two mem_rd cycles.
REQ-035 start pulsed during RDB with different addresses -> ignored; results unchanged; exactly one done.
REQ-036 reset asserted in CAPB -> no done; opA=opB=0; a subsequent fetch completes correctly.
REQ-037 start held high for 20 cycles -> done every 5 cycles; opA/opB remain stable between done pulses.
